key_msg_loader: RTL and testbench
=================================

Name: key_msg_loader

Overview:
- Front-end bit-level receiver for the XOR cipher datapath.
- Accepts a framed serial stream from the ESP32: asynchronous bit clock, data line and active-low frame select.
- Synchronises the stream into the core clock domain and emits one-cycle bit strobes qualified as key or message load.
- These strobes directly drive the key and message deserializers. Frame completion and framing errors are reported to the top level.

Parameters:
KEY_SIZE, 32, number of key bits at the start of each frame
MSG_SIZE, 512, number of message bits following the key
SYNC_STAGES, 2, flip-flop stages on each asynchronous input (minimum 2)

Ports:
clk  input  1  core clock
rst_n  input  1  reset, asynchronous, active-low
ena  input  1  block enable; when low, FSM and counter hold and bit edges are discarded
iSck  input  1  ESP32 bit clock, asynchronous to clk; data is valid on its rising edge
iSdi  input  1  ESP32 serial data
iCs_n  input  1  frame select, active-low
oData_bit  output  1  sampled data bit, valid while oLoad_key or oLoad_msg is high
oLoad_key  output  1  one-cycle strobe: oData_bit is a key bit
oLoad_msg  output  1  one-cycle strobe: oData_bit is a message bit
oFrame_done  output  1  one-cycle pulse when the frame completes with exactly KEY_SIZE+MSG_SIZE bits
oFrame_err  output  1  sticky error flag
oBusy  output  1  high in KEY or MSG state
oBit_count  output  $clog2(MSG_SIZE)+1  bits accepted in the current phase

Behaviour:
- Reset values:
  - Synchroniser chains: iSck chain resets to 0, iCs_n chain resets to 1, iSdi chain resets to 0.
  - All outputs 0; state IDLE; counter 0.
- Synchronisation and edge detection:
  - Each input passes through SYNC_STAGES flops.
  - One extra register on synchronised sck and cs_n provides edge detection.
- A bit event is a synchronised sck rising edge while synchronised cs_n is low and ena is high.
  - Strobe latency from the raw iSck edge is SYNC_STAGES+1 clk cycles.
  - oData_bit is registered with the strobe from the synchronised sdi sampled in the same cycle as the edge detection.
- Input timing: iSck high and low phases must each be at least SYNC_STAGES+1 clk periods. Narrower pulses are unsupported.
- FSM states: IDLE, KEY, MSG, DONE, ERR.
  - IDLE: synchronised cs_n falling edge -> KEY, counter cleared. Bit events are ignored.
  - KEY: each bit event -> oLoad_key=1 for one cycle, counter++. When counter reaches KEY_SIZE, go to MSG and clear the counter (same cycle as the last key strobe).
  - MSG: each bit event -> oLoad_msg=1 for one cycle, counter++. When counter reaches MSG_SIZE, go to DONE and pulse oFrame_done once.
  - DONE: counter holds MSG_SIZE. cs_n rising -> IDLE. Any bit event -> ERR (overrun), and no strobe is issued.
  - ERR: oFrame_err=1; no strobes. A cs_n falling edge clears oFrame_err and enters KEY (new frame).
- Early frame end: cs_n rising in KEY or MSG -> ERR (short frame).
- Simultaneous sck-rise and cs_n-rise in the same cycle: the bit is processed first, then cs_n.
  - If that bit completes the frame -> DONE, then IDLE on the next cycle.
  - Otherwise -> ERR.
- oLoad_key and oLoad_msg are never high in the same cycle; each strobe is exactly one cycle wide.
- ena low:
  - Edge detectors still update, so a suppressed edge is not replayed when ena rises.
  - State, counter and oFrame_err hold; no strobes.
- Reset mid-frame: all state clears immediately (asynchronous). A frame in progress is abandoned; the bits that follow are ignored until the next cs_n falling edge.
- Counter width: $clog2(MSG_SIZE)+1 bits, so the value MSG_SIZE fits without wrap.

Test Plan:
- Nominal frame: cs_n low, 32 key bits 0xA5A5_0F0F then 512 message bits of alternating 0x3C bytes, cs_n high.
  - Exactly 32 oLoad_key and 512 oLoad_msg strobes, with oData_bit matching MSB-first order.
  - oFrame_done pulses once, after the 512th message bit strobe.
  - oFrame_err stays 0; oBusy drops after the last bit.
- Short frame: cs_n rises after 32 key and 100 message bits.
  - oFrame_err=1, oBusy=0, no oFrame_done.
  - The next frame, 544 bits, clears the error and completes normally.
- Overrun: 545 bits sent in one frame.
  - oFrame_done pulses after bit 544; bit 545 produces no strobe and sets oFrame_err.
- Latency check, SYNC_STAGES=2: a single iSck rising edge must produce the oLoad_key strobe exactly 3 clk cycles later.
- ena low for 10 bits mid-message: those bits produce no strobes and oBit_count is frozen.
  - After ena returns high, counting resumes with no replayed edge.
- rst_n asserted asynchronously after 200 message bits: all outputs are 0 immediately.
  - Continued iSck edges without a new cs_n falling edge produce no strobes.

Source files
------------

// File: rtl/key_msg_loader.sv
// Serial frame receiver: synchronises ESP32 sck/sdi/cs_n into clk and emits key/message bit strobes
// (SYNC_STAGES+1 cycles after the raw sck edge); no backpressure, downstream must accept every strobe.
module key_msg_loader #(
    parameter int KEY_SIZE    = 32,
    parameter int MSG_SIZE    = 512,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic                       iSck,
    input  logic                       iSdi,
    input  logic                       iCs_n,
    output logic                       oData_bit,
    output logic                       oLoad_key,
    output logic                       oLoad_msg,
    output logic                       oFrame_done,
    output logic                       oFrame_err,
    output logic                       oBusy,
    output logic [$clog2(MSG_SIZE):0]  oBit_count
);
    localparam int CW = $clog2(MSG_SIZE) + 1;
    localparam logic [CW-1:0] KEY_LAST = CW'(KEY_SIZE - 1);
    localparam logic [CW-1:0] MSG_LAST = CW'(MSG_SIZE - 1);
    localparam logic [CW-1:0] MSG_FULL = CW'(MSG_SIZE);

    typedef enum logic [2:0] {S_IDLE, S_KEY, S_MSG, S_DONE, S_ERR} state_t;
    state_t state;

    logic [SYNC_STAGES-1:0] sck_sync, sdi_sync, cs_sync, flush;
    logic sck_d, cs_d, cs_armed;
    logic sck_s, sdi_s, cs_s;
    logic sck_rise, cs_rise, cs_fall, bit_ev;

    assign sck_s = sck_sync[SYNC_STAGES-1];
    assign sdi_s = sdi_sync[SYNC_STAGES-1];
    assign cs_s  = cs_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync <= '0;
            sdi_sync <= '0;
            cs_sync  <= '1;
            flush    <= '0;
            sck_d    <= 1'b0;
            cs_d     <= 1'b1;
            cs_armed <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], iSck};
            sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], iSdi};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], iCs_n};
            flush    <= {flush[SYNC_STAGES-2:0], 1'b1};
            sck_d    <= sck_s;
            cs_d     <= cs_s;
            // The cs chain resets high, so a pin already low at reset release would look like a
            // falling edge. Only arm once a genuine high level has passed through the chain.
            cs_armed <= cs_armed | (flush[SYNC_STAGES-1] & cs_s);
        end
    end

    assign sck_rise = sck_s & ~sck_d;
    assign cs_rise  = cs_s & ~cs_d;
    assign cs_fall  = ~cs_s & cs_d & cs_armed;
    // A bit coinciding with cs_n rising still belongs to the frame.
    assign bit_ev   = ena & sck_rise & (~cs_s | cs_rise);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            oBit_count  <= '0;
            oData_bit   <= 1'b0;
            oLoad_key   <= 1'b0;
            oLoad_msg   <= 1'b0;
            oFrame_done <= 1'b0;
            oFrame_err  <= 1'b0;
            oBusy       <= 1'b0;
        end else begin
            oLoad_key   <= 1'b0;
            oLoad_msg   <= 1'b0;
            oFrame_done <= 1'b0;
            if (ena) begin
                case (state)
                    S_IDLE: begin
                        if (cs_fall) begin
                            state      <= S_KEY;
                            oBusy      <= 1'b1;
                            oBit_count <= '0;
                        end
                    end
                    S_KEY: begin
                        if (bit_ev) begin
                            oLoad_key <= 1'b1;
                            oData_bit <= sdi_s;
                            if (oBit_count == KEY_LAST) begin
                                state      <= S_MSG;
                                oBit_count <= '0;
                            end else begin
                                oBit_count <= oBit_count + 1'b1;
                            end
                        end
                        if (cs_rise) begin
                            state      <= S_ERR;
                            oBusy      <= 1'b0;
                            oFrame_err <= 1'b1;
                        end
                    end
                    S_MSG: begin
                        if (bit_ev) begin
                            oLoad_msg <= 1'b1;
                            oData_bit <= sdi_s;
                            if (oBit_count == MSG_LAST) begin
                                state       <= S_DONE;
                                oBusy       <= 1'b0;
                                oFrame_done <= 1'b1;
                                oBit_count  <= MSG_FULL;
                            end else begin
                                oBit_count <= oBit_count + 1'b1;
                            end
                        end
                        if (cs_rise && !(bit_ev && oBit_count == MSG_LAST)) begin
                            state      <= S_ERR;
                            oBusy      <= 1'b0;
                            oFrame_err <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        // Level test on cs_n also covers a rise that landed with the final bit.
                        if (bit_ev) begin
                            state      <= S_ERR;
                            oFrame_err <= 1'b1;
                        end else if (cs_s) begin
                            state <= S_IDLE;
                        end
                    end
                    S_ERR: begin
                        if (cs_fall) begin
                            state      <= S_KEY;
                            oBusy      <= 1'b1;
                            oFrame_err <= 1'b0;
                            oBit_count <= '0;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        oBusy <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_key_msg_loader.sv
// Scoreboard bench for key_msg_loader: stimulus pushes expected strobes, a negedge monitor pops them.
`timescale 1ns/1ps
module tb_key_msg_loader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       iSck = 1'b0;
    logic       iSdi = 1'b0;
    logic       iCs_n = 1'b1;
    logic       oData_bit, oLoad_key, oLoad_msg, oFrame_done, oFrame_err, oBusy;
    logic [9:0] oBit_count;

    key_msg_loader #(.KEY_SIZE(32), .MSG_SIZE(512), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .iSck(iSck), .iSdi(iSdi), .iCs_n(iCs_n),
        .oData_bit(oData_bit), .oLoad_key(oLoad_key), .oLoad_msg(oLoad_msg),
        .oFrame_done(oFrame_done), .oFrame_err(oFrame_err), .oBusy(oBusy),
        .oBit_count(oBit_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   kind;   // 0 key strobe, 1 msg strobe, 2 frame done
        logic dbit;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_key = 0, n_msg = 0, n_done = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (oLoad_key || oLoad_msg) begin
                    checks++;
                    if (oLoad_key) n_key++;
                    if (oLoad_msg) n_msg++;
                    if (oLoad_key && oLoad_msg) begin
                        errors++;
                        $display("FAIL strobe_overlap key=1 msg=1 at %0t", $time);
                    end else if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_strobe key=%0b msg=%0b at %0t", oLoad_key, oLoad_msg, $time);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.kind != (oLoad_key ? 0 : 1) || e.dbit != oData_bit) begin
                            errors++;
                            $display("FAIL strobe actual kind=%0d bit=%0b expected kind=%0d bit=%0b at %0t",
                                     oLoad_key ? 0 : 1, oData_bit, e.kind, e.dbit, $time);
                        end
                    end
                end
                if (oFrame_done) begin
                    checks++;
                    n_done++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_done at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.kind != 2) begin
                            errors++;
                            $display("FAIL done actual kind=2 expected kind=%0d at %0t", e.kind, $time);
                        end
                    end
                end
            end
        end
    end

    function automatic logic bit_at(input int i);
        logic [31:0] k;
        logic [7:0]  b;
        k = 32'hA5A5_0F0F;
        if (i < 32) return k[31-i];
        if (i >= 544) return 1'b1;
        b = (((i - 32) / 8) % 2 == 0) ? 8'h3C : 8'hC3;
        return b[7 - ((i - 32) % 8)];
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int idx);
        exp_t e;
        if (idx < 32) begin
            e.kind = 0; e.dbit = bit_at(idx); exp_q.push_back(e);
        end else if (idx < 544) begin
            e.kind = 1; e.dbit = bit_at(idx); exp_q.push_back(e);
            if (idx == 543) begin
                e.kind = 2; e.dbit = 1'b0; exp_q.push_back(e);
            end
        end
    endtask

    task automatic send_bits(input int from, input int n, input bit expect_on);
        for (int i = from; i < from + n; i++) begin
            iSdi = bit_at(i);
            if (expect_on) push_exp(i);
            wait_clk(4);
            iSck = 1'b1;
            wait_clk(4);
            iSck = 1'b0;
        end
        wait_clk(4);
    endtask

    task automatic frame_start();
        iCs_n = 1'b0;
        wait_clk(6);
    endtask

    task automatic frame_end();
        iCs_n = 1'b1;
        wait_clk(6);
    endtask

    initial begin
        int cyc;
        int k0, m0, d0;

        // Reset state
        wait_clk(3);
        chk("reset_outputs", int'({oData_bit, oLoad_key, oLoad_msg, oFrame_done, oFrame_err, oBusy}), 0);
        chk("reset_count", int'(oBit_count), 0);
        rst_n = 1'b1;
        wait_clk(5);
        chk("idle_busy", int'(oBusy), 0);

        // Nominal frame, first bit also measures strobe latency
        k0 = n_key; m0 = n_msg; d0 = n_done;
        frame_start();
        chk("start_busy", int'(oBusy), 1);
        iSdi = bit_at(0);
        push_exp(0);
        wait_clk(4);
        iSck = 1'b1;
        cyc = 0;
        while (!oLoad_key && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("latency", cyc, 3);
        wait_clk(2);
        iSck = 1'b0;
        send_bits(1, 543, 1'b1);
        chk("nom_busy_done", int'(oBusy), 0);
        chk("nom_count_full", int'(oBit_count), 512);
        frame_end();
        chk("nom_err", int'(oFrame_err), 0);
        chk("nom_keys", n_key - k0, 32);
        chk("nom_msgs", n_msg - m0, 512);
        chk("nom_done", n_done - d0, 1);

        // Short frame
        d0 = n_done;
        frame_start();
        send_bits(0, 132, 1'b1);
        chk("short_count", int'(oBit_count), 100);
        frame_end();
        chk("short_err", int'(oFrame_err), 1);
        chk("short_busy", int'(oBusy), 0);
        chk("short_no_done", n_done - d0, 0);

        // Recovery frame
        d0 = n_done;
        frame_start();
        chk("recover_err_clear", int'(oFrame_err), 0);
        chk("recover_busy", int'(oBusy), 1);
        send_bits(0, 544, 1'b1);
        frame_end();
        chk("recover_err", int'(oFrame_err), 0);
        chk("recover_done", n_done - d0, 1);

        // Overrun: the 545th bit gives no strobe and flags an error
        d0 = n_done;
        frame_start();
        send_bits(0, 544, 1'b1);
        chk("ovr_done", n_done - d0, 1);
        chk("ovr_count_hold", int'(oBit_count), 512);
        chk("ovr_err_before", int'(oFrame_err), 0);
        send_bits(544, 1, 1'b1);
        chk("ovr_err", int'(oFrame_err), 1);
        chk("ovr_busy", int'(oBusy), 0);
        frame_end();
        chk("ovr_err_sticky", int'(oFrame_err), 1);

        // ena low for 10 message bits
        k0 = n_key; m0 = n_msg; d0 = n_done;
        frame_start();
        chk("ena_err_clear", int'(oFrame_err), 0);
        send_bits(0, 132, 1'b1);
        chk("ena_count_before", int'(oBit_count), 100);
        ena = 1'b0;
        send_bits(132, 10, 1'b0);
        chk("ena_count_frozen", int'(oBit_count), 100);
        ena = 1'b1;
        wait_clk(10);
        chk("ena_no_replay", int'(oBit_count), 100);
        send_bits(132, 412, 1'b1);
        chk("ena_msgs", n_msg - m0, 512);
        chk("ena_done", n_done - d0, 1);
        frame_end();

        // Asynchronous reset mid-message
        frame_start();
        send_bits(0, 232, 1'b1);
        chk("rst_pre_count", int'(oBit_count), 200);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", int'({oData_bit, oLoad_key, oLoad_msg, oFrame_done, oFrame_err, oBusy}), 0);
        chk("rst_async_count", int'(oBit_count), 0);
        wait_clk(2);
        rst_n = 1'b1;
        k0 = n_key; m0 = n_msg;
        send_bits(232, 20, 1'b0);
        chk("rst_no_strobes", (n_key - k0) + (n_msg - m0), 0);
        chk("rst_busy", int'(oBusy), 0);
        chk("rst_count", int'(oBit_count), 0);
        frame_end();

        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
